// File: rtl/hiscore_ram_arbiter.sv
// hiscore_ram_arbiter: shares one game RAM port between the CPU and the
// hiscore engine by pausing the CPU, letting the bus settle, then granting.
//
// Ports:
//   clk, reset (sync, active-low)
//   hs_access, hs_write, hs_address, hs_data_in -> hiscore engine request
//   hs_data_out, hs_grant                       -> hiscore engine response
//   cpu_address, cpu_dout, cpu_wr, cpu_bus_idle -> game CPU side
//   pause_cpu                                   -> CPU pause request
//   ram_address, ram_data, ram_we, ram_q        -> shared RAM port
module hiscore_ram_arbiter #(
    parameter int         HS_ADDRESSWIDTH = 10,
    parameter logic [7:0] SETTLE_CYCLES   = 8'd4,
    parameter logic [7:0] RELEASE_CYCLES  = 8'd2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hs_access,
    input  logic                       hs_write,
    input  logic [HS_ADDRESSWIDTH-1:0] hs_address,
    input  logic [7:0]                 hs_data_in,
    output logic [7:0]                 hs_data_out,
    output logic                       hs_grant,
    input  logic [HS_ADDRESSWIDTH-1:0] cpu_address,
    input  logic [7:0]                 cpu_dout,
    input  logic                       cpu_wr,
    input  logic                       cpu_bus_idle,
    output logic                       pause_cpu,
    output logic [HS_ADDRESSWIDTH-1:0] ram_address,
    output logic [7:0]                 ram_data,
    output logic                       ram_we,
    input  logic [7:0]                 ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        PAUSE_REQ,
        SETTLE,
        GRANT,
        RELEASE
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       was_grant;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            pause_cpu   <= 1'b0;
            hs_data_out <= 8'h00;
            was_grant   <= 1'b0;
        end else begin
            // RAM data for an address presented in GRANT arrives one
            // cycle later, so capture it the cycle after GRANT.
            was_grant <= (state == GRANT);
            if (was_grant) begin
                hs_data_out <= ram_q;
            end
            unique case (state)
                IDLE: begin
                    if (hs_access) begin
                        state     <= PAUSE_REQ;
                        pause_cpu <= 1'b1;
                    end
                end
                PAUSE_REQ: begin
                    if (!hs_access) begin
                        state <= RELEASE;
                        cnt   <= RELEASE_CYCLES;
                    end else if (cpu_bus_idle) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_CYCLES;
                    end
                end
                SETTLE: begin
                    if (!hs_access) begin
                        state <= RELEASE;
                        cnt   <= RELEASE_CYCLES;
                    end else if (cnt == 8'd0) begin
                        state <= GRANT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GRANT: begin
                    if (!hs_access) begin
                        state <= RELEASE;
                        cnt   <= RELEASE_CYCLES;
                    end
                end
                RELEASE: begin
                    // A fresh request re-settles without letting the CPU go.
                    if (hs_access) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_CYCLES;
                    end else if (cnt == 8'd0) begin
                        state     <= IDLE;
                        pause_cpu <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pause_cpu <= 1'b0;
                end
            endcase
        end
    end

    assign hs_grant = (state == GRANT);

    always_comb begin
        ram_address = cpu_address;
        ram_data    = cpu_dout;
        ram_we      = cpu_wr;
        unique case (state)
            GRANT: begin
                ram_address = hs_address;
                ram_data    = hs_data_in;
                ram_we      = hs_write & hs_access;
            end
            SETTLE, RELEASE: begin
                ram_we = 1'b0;
            end
            default: begin
                ram_we = cpu_wr;
            end
        endcase
    end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb_hiscore_ram_arbiter: directed and randomized checks of the hiscore
// RAM arbiter against a cycle-level reference model.
module tb_hiscore_ram_arbiter;

    localparam int AW = 10;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_SETTL = 2;
    localparam int M_OWN   = 3;
    localparam int M_REL   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          hs_access;
    logic          hs_write;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_data_in;
    logic [7:0]    hs_data_out;
    logic          hs_grant;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_dout;
    logic          cpu_wr;
    logic          cpu_bus_idle;
    logic          pause_cpu;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_we;
    logic [7:0]    ram_q;

    always #5 clk = ~clk;

    hiscore_ram_arbiter #(
        .HS_ADDRESSWIDTH(AW),
        .SETTLE_CYCLES  (8'd4),
        .RELEASE_CYCLES (8'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hs_access   (hs_access),
        .hs_write    (hs_write),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_data_out (hs_data_out),
        .hs_grant    (hs_grant),
        .cpu_address (cpu_address),
        .cpu_dout    (cpu_dout),
        .cpu_wr      (cpu_wr),
        .cpu_bus_idle(cpu_bus_idle),
        .pause_cpu   (pause_cpu),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .ram_q       (ram_q)
    );

    int checks   = 0;
    int failures = 0;

    int         m_mode;
    int         m_left;
    bit         m_prev_own;
    logic [7:0] m_dout;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        logic          ew;
        if (m_mode == M_OWN) begin
            ea = hs_address;
            ed = hs_data_in;
            ew = hs_write & hs_access;
        end else begin
            ea = cpu_address;
            ed = cpu_dout;
            ew = (m_mode == M_IDLE || m_mode == M_WAIT) ? cpu_wr : 1'b0;
        end
        check("pause_cpu", {31'd0, pause_cpu}, {31'd0, m_mode != M_IDLE});
        check("hs_grant", {31'd0, hs_grant}, {31'd0, m_mode == M_OWN});
        check("ram_address", {22'd0, ram_address}, {22'd0, ea});
        check("ram_data", {24'd0, ram_data}, {24'd0, ed});
        check("ram_we", {31'd0, ram_we}, {31'd0, ew});
        check("hs_data_out", {24'd0, hs_data_out}, {24'd0, m_dout});
    endtask

    task automatic model_step();
        if (!reset) begin
            m_mode     = M_IDLE;
            m_left     = 0;
            m_prev_own = 1'b0;
            m_dout     = 8'h00;
        end else begin
            if (m_prev_own) m_dout = ram_q;
            m_prev_own = (m_mode == M_OWN);
            case (m_mode)
                M_IDLE: if (hs_access) m_mode = M_WAIT;
                M_WAIT: begin
                    if (!hs_access) begin
                        m_mode = M_REL; m_left = 2;
                    end else if (cpu_bus_idle) begin
                        m_mode = M_SETTL; m_left = 4;
                    end
                end
                M_SETTL: begin
                    if (!hs_access) begin
                        m_mode = M_REL; m_left = 2;
                    end else if (m_left == 0) m_mode = M_OWN;
                    else m_left = m_left - 1;
                end
                M_OWN: if (!hs_access) begin
                    m_mode = M_REL; m_left = 2;
                end
                default: begin
                    if (hs_access) begin
                        m_mode = M_SETTL; m_left = 4;
                    end else if (m_left == 0) m_mode = M_IDLE;
                    else m_left = m_left - 1;
                end
            endcase
        end
    endtask

    // Check the current cycle, then advance one clock.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rand_misc();
        cpu_address = AW'($urandom);
        cpu_dout    = 8'($urandom);
        cpu_wr      = 1'($urandom);
        hs_address  = AW'($urandom);
        hs_data_in  = 8'($urandom);
        hs_write    = 1'($urandom);
        ram_q       = 8'($urandom);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        hs_access    = 1'b0;
        hs_write     = 1'b0;
        hs_address   = '0;
        hs_data_in   = 8'h00;
        cpu_address  = '0;
        cpu_dout     = 8'h00;
        cpu_wr       = 1'b0;
        cpu_bus_idle = 1'b0;
        ram_q        = 8'h00;

        @(posedge clk);
        model_step();
        #1;
        cycle();
        reset = 1'b1;
        rand_misc();
        cycle();
        cycle();

        // Request with an idle bus: pause next cycle, grant after 7 clocks.
        hs_access    = 1'b1;
        cpu_bus_idle = 1'b1;
        hs_write     = 1'b0;
        cycle();
        check("pause_next", {31'd0, pause_cpu}, 32'd1);
        n = 1;
        while (!hs_grant && n < 20) begin
            cycle();
            n++;
        end
        check("grant_latency", n, 32'd7);

        // Hiscore write routed straight through in GRANT.
        hs_address = 10'h0AB;
        hs_write   = 1'b1;
        hs_data_in = 8'h5A;
        #1;
        check("gr_wr_addr", {22'd0, ram_address}, 32'h0AB);
        check("gr_wr_we", {31'd0, ram_we}, 32'd1);
        check("gr_wr_data", {24'd0, ram_data}, 32'h5A);
        cycle();

        // Hiscore read: data returns two clocks after the address.
        hs_write   = 1'b0;
        hs_address = 10'h123;
        cycle();
        ram_q = 8'h3C;
        cycle();
        ram_q = 8'h99;
        check("read_latency", {24'd0, hs_data_out}, 32'h3C);
        cycle();

        // Drop then re-raise on the second RELEASE cycle.
        hs_access = 1'b0;
        cycle();
        cycle();
        hs_access = 1'b1;
        check("rel2_pause", {31'd0, pause_cpu}, 32'd1);
        cycle();
        check("resettle_pause", {31'd0, pause_cpu}, 32'd1);
        check("resettle_nogrant", {31'd0, hs_grant}, 32'd0);
        n = 0;
        while (!hs_grant && n < 20) begin
            cycle();
            n++;
        end
        check("regrant_latency", n, 32'd5);

        // Reset in the middle of a hiscore write.
        hs_write = 1'b1;
        reset    = 1'b0;
        cycle();
        reset  = 1'b1;
        cpu_wr = 1'b1;
        #1;
        check("rst_pause", {31'd0, pause_cpu}, 32'd0);
        check("rst_grant", {31'd0, hs_grant}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd1);
        check("rst_dout", {24'd0, hs_data_out}, 32'h00);
        cycle();

        // Busy CPU bus: stay paused-waiting for 20 cycles with no grant.
        hs_access = 1'b0;
        cycle();
        cycle();
        cycle();
        cycle();
        hs_access    = 1'b1;
        cpu_bus_idle = 1'b0;
        for (int i = 0; i < 21; i++) begin
            rand_misc();
            cycle();
        end
        check("busy_pause", {31'd0, pause_cpu}, 32'd1);
        check("busy_nogrant", {31'd0, hs_grant}, 32'd0);
        hs_access = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rand_misc();
            if ($urandom_range(7, 0) == 0) hs_access = ~hs_access;
            cpu_bus_idle = ($urandom_range(2, 0) == 0);
            reset = ($urandom_range(99, 0) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hiscore_ram_arbiter.md
HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

Interface
REQ-001 SHALL have parameter HS_ADDRESSWIDTH, default 10: width of the game RAM address.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, 8-bit: pause-to-grant settle count.
REQ-003 SHALL have parameter RELEASE_CYCLES, default 2, 8-bit: grant-to-unpause release count.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port hs_access  in  1  hiscore engine requests game RAM (read or write).
REQ-007 SHALL have port hs_write  in  1  hiscore write strobe, active high.
REQ-008 SHALL have port hs_address  in  HS_ADDRESSWIDTH  hiscore RAM address.
REQ-009 SHALL have port hs_data_in  in  8  hiscore write data.
REQ-010 SHALL have port hs_data_out  out  8  registered RAM read data returned to the hiscore engine.
REQ-011 SHALL have port hs_grant  out  1  high while the hiscore engine owns the RAM port.
REQ-012 SHALL have port cpu_address  in  HS_ADDRESSWIDTH  game CPU address.
REQ-013 SHALL have port cpu_dout  in  8  game CPU write data.
REQ-014 SHALL have port cpu_wr  in  1  game CPU write strobe.
REQ-015 SHALL have port cpu_bus_idle  in  1  high when the CPU is between bus cycles.
REQ-016 SHALL have port pause_cpu  out  1  registered CPU pause request.
REQ-017 SHALL have port ram_address  out  HS_ADDRESSWIDTH  muxed RAM address.
REQ-018 SHALL have port ram_data  out  8  muxed RAM write data.
REQ-019 SHALL have port ram_we  out  1  muxed RAM write enable.
REQ-020 SHALL have port ram_q  in  8  RAM read data, valid the cycle after its address is presented.

Function
REQ-021 SHALL implement states IDLE, PAUSE_REQ, SETTLE, GRANT and RELEASE, plus an 8-bit down-counter cnt.
REQ-022 IDLE: on hs_access=1, go to PAUSE_REQ; otherwise stay.
REQ-023 PAUSE_REQ: on hs_access=0, go to RELEASE with cnt<=RELEASE_CYCLES.
REQ-024 PAUSE_REQ: else on cpu_bus_idle=1, go to SETTLE with cnt<=SETTLE_CYCLES; else stay, with no timeout.
REQ-025 SETTLE: on hs_access=0, go to RELEASE with cnt<=RELEASE_CYCLES.
REQ-026 SETTLE: else on cnt=0, go to GRANT; else decrement cnt, so SETTLE lasts SETTLE_CYCLES+1 cycles.
REQ-027 GRANT: stay while hs_access=1; on hs_access=0, go to RELEASE with cnt<=RELEASE_CYCLES.
REQ-028 RELEASE: on hs_access=1, go to SETTLE with cnt<=SETTLE_CYCLES, keeping the CPU paused; this rule has priority.
REQ-029 RELEASE: else on cnt=0, go to IDLE; else decrement cnt.
REQ-030 pause_cpu SHALL be registered and SHALL equal 1 in every state except IDLE.
REQ-031 hs_grant SHALL be 1 exactly when the state is GRANT.
REQ-032 In GRANT, the outputs SHALL be combinational: ram_address=hs_address, ram_data=hs_data_in, ram_we=hs_write&hs_access.
REQ-033 In IDLE and PAUSE_REQ, the outputs SHALL be combinational: ram_address=cpu_address, ram_data=cpu_dout, ram_we=cpu_wr.
REQ-034 In SETTLE and RELEASE, ram_address and ram_data SHALL follow the CPU and ram_we SHALL be forced 0.
REQ-035 hs_write outside GRANT SHALL be ignored (no RAM write).
REQ-036 hs_data_out SHALL load ram_q every cycle in which the previous cycle's state was GRANT, and SHALL hold otherwise.
REQ-037 hs_data_out read latency SHALL be 2 clocks from hs_address (RAM plus output register).
REQ-038 cpu_bus_idle SHALL be sampled only in PAUSE_REQ.
REQ-039 If hs_access and cpu_wr are both high in IDLE, the CPU write SHALL complete that cycle.
REQ-040 Counter arithmetic SHALL be unsigned 8-bit with no wrap, since it only decrements when cnt>0.

Reset
REQ-041 While reset=0 at a clock edge, the block SHALL set state=IDLE, cnt=0, pause_cpu=0 and hs_data_out=8'h00.
REQ-042 Reset SHALL take effect from any state, including mid-GRANT, and the first post-reset cycle SHALL route the RAM port to the CPU with ram_we=cpu_wr.

Verification
REQ-043 The bench SHALL cover: hs_access=1 and cpu_bus_idle=1 in IDLE -> pause_cpu=1 next cycle, hs_grant=1 after 1+1+5 cycles with SETTLE_CYCLES=4.
REQ-044 The bench SHALL cover: cpu_bus_idle held 0 for 20 cycles -> state stays PAUSE_REQ, CPU writes pass through, hs_grant=0.
REQ-045 The bench SHALL cover: in GRANT, hs_address=10'h0AB, hs_write=1, hs_data_in=8'h5A -> ram_address=0AB, ram_we=1, ram_data=5A in the same cycle.
REQ-046 The bench SHALL cover: in GRANT, read with ram_q=8'h3C -> hs_data_out=3C two clocks after the address.
REQ-047 The bench SHALL cover: hs_access dropped then re-raised on the second RELEASE cycle -> pause_cpu stays 1, with SETTLE re-entered and no IDLE visit.
REQ-048 The bench SHALL cover: reset=0 asserted mid-GRANT with hs_write=1 -> next cycle pause_cpu=0, hs_grant=0, ram_we follows cpu_wr.
